// File: rtl/load_store_unit_pkg.sv
// Shared ISA op codes, LSU state/size types and the op decode helpers used by
// the load/store unit and its load extender.
package load_store_unit_pkg;

    localparam logic [7:0] ALU_OPERATIONS_LB  = 8'h30;
    localparam logic [7:0] ALU_OPERATIONS_LH  = 8'h31;
    localparam logic [7:0] ALU_OPERATIONS_LW  = 8'h32;
    localparam logic [7:0] ALU_OPERATIONS_LBU = 8'h33;
    localparam logic [7:0] ALU_OPERATIONS_LHU = 8'h34;
    localparam logic [7:0] ALU_OPERATIONS_SB  = 8'h38;
    localparam logic [7:0] ALU_OPERATIONS_SH  = 8'h39;
    localparam logic [7:0] ALU_OPERATIONS_SW  = 8'h3A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // SIZE_NONE marks an op code that is not a memory access at all.
    typedef enum logic [1:0] {
        SIZE_NONE = 2'd0,
        SIZE_BYTE = 2'd1,
        SIZE_HALF = 2'd2,
        SIZE_WORD = 2'd3
    } mem_size_t;

    typedef struct packed {
        mem_size_t size;
        logic      is_store;
        logic      is_unsigned;
    } op_decode_t;

    function automatic op_decode_t decode_op(input logic [7:0] op);
        op_decode_t d;
        d = '{size: SIZE_NONE, is_store: 1'b0, is_unsigned: 1'b0};
        case (op)
            ALU_OPERATIONS_LB:  d.size = SIZE_BYTE;
            ALU_OPERATIONS_LH:  d.size = SIZE_HALF;
            ALU_OPERATIONS_LW:  d.size = SIZE_WORD;
            ALU_OPERATIONS_LBU: begin d.size = SIZE_BYTE; d.is_unsigned = 1'b1; end
            ALU_OPERATIONS_LHU: begin d.size = SIZE_HALF; d.is_unsigned = 1'b1; end
            ALU_OPERATIONS_SB:  begin d.size = SIZE_BYTE; d.is_store = 1'b1; end
            ALU_OPERATIONS_SH:  begin d.size = SIZE_HALF; d.is_store = 1'b1; end
            ALU_OPERATIONS_SW:  begin d.size = SIZE_WORD; d.is_store = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_HALF: mis = off[0];
            SIZE_WORD: mis = (off != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Loads always fetch the full word; lane selection happens on return.
    function automatic logic [3:0] byte_enables(input op_decode_t d, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (d.is_store) begin
            case (d.size)
                SIZE_BYTE: be = 4'b0001 << off;
                SIZE_HALF: be = 4'b0011 << off;
                default:   be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input mem_size_t size, input logic [31:0] data);
        logic [31:0] w;
        case (size)
            SIZE_BYTE: w = {4{data[7:0]}};
            SIZE_HALF: w = {2{data[15:0]}};
            default:   w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half lane out of a returned memory word and
// sign- or zero-extends it to 32 bits.
module load_extender
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{byte_off, 3'b000} +: 8];
        half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            SIZE_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            SIZE_WORD: data = rdata;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one op from execute, runs the
// memory request/response handshake and returns an extended load value.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  alu_operation,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_misaligned,
    output lsu_state_t  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // (or mem_req and mem_gnt) are both high; the offering side holds its
    // payload stable until then.

    lsu_state_t  state_q, state_d;
    op_decode_t  op_q, op_in;
    logic [31:0] addr_q, wdata_q, resp_data_q, load_value;
    logic [3:0]  be_q;
    logic        resp_mis_q, mis_in, accept, capture;

    assign op_in   = decode_op(alu_operation);
    assign mis_in  = is_misaligned(op_in.size, addr[1:0]);
    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign capture = (state_q == ST_WAIT) && mem_rvalid;

    load_extender u_load_extender (
        .rdata       (mem_rdata),
        .byte_off    (addr_q[1:0]),
        .size        (op_q.size),
        .is_unsigned (op_q.is_unsigned),
        .data        (load_value)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            op_q        <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_mis_q  <= 1'b0;
        end else if (accept) begin
            op_q        <= op_in;
            addr_q      <= addr;
            be_q        <= byte_enables(op_in, addr[1:0]);
            wdata_q     <= lane_replicate(op_in.size, store_data);
            resp_data_q <= '0;
            resp_mis_q  <= mis_in;
        end else if (capture) begin
            resp_data_q <= load_value;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                // Non-memory and misaligned ops skip the bus entirely.
                if (req_valid)
                    state_d = (op_in.size == SIZE_NONE || mis_in) ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                mem_req   = 1'b1;
                mem_we    = op_q.is_store;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = be_q;
                mem_wdata = wdata_q;
                if (mem_gnt) state_d = op_q.is_store ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_data       = resp_data_q;
    assign resp_misaligned = resp_mis_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-high (1 = reset).
REQ-003 SHALL have port req_valid  in  1  execute stage presents a memory op.
REQ-004 SHALL have port req_ready  out  1  unit accepts the op (IDLE only).
REQ-005 SHALL have port alu_operation  in  8  op code; only LB/LH/LW/LBU/LHU/SB/SH/SW valid.
REQ-006 SHALL have port addr  in  32  byte address (ALU sum result).
REQ-007 SHALL have port store_data  in  32  rs2 value, LSB-justified.
REQ-008 SHALL have port mem_req  out  1  memory request.
REQ-009 SHALL have port mem_we  out  1  1 = store.
REQ-010 SHALL have port mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-011 SHALL have port mem_be  out  4  byte enables.
REQ-012 SHALL have port mem_wdata  out  32  lane-replicated store data.
REQ-013 SHALL have port mem_gnt  in  1  memory accepted request.
REQ-014 SHALL have port mem_rvalid  in  1  load data valid.
REQ-015 SHALL have port mem_rdata  in  32  load word.
REQ-016 SHALL have port resp_valid  out  1  result/completion available.
REQ-017 SHALL have port resp_ready  in  1  writeback consumes response.
REQ-018 SHALL have port resp_data  out  32  extended load value (0 for stores).
REQ-019 SHALL have port resp_misaligned  out  1  misaligned-access flag.

Function
REQ-020 SHALL implement FSM IDLE, REQ, WAIT, RESP.
REQ-021 IDLE: req_ready=1; on req_valid SHALL register op, addr, store_data; aligned -> REQ; misaligned -> RESP with resp_misaligned=1 and no mem_req.
REQ-022 Misaligned SHALL mean LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; byte ops never misaligned.
REQ-023 REQ: mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata stable until mem_gnt; on gnt, store -> RESP, load -> WAIT.
REQ-024 mem_be SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word); mem_be=1111 for loads.
REQ-025 mem_wdata SHALL replicate byte x4 (SB), half x2 (SH), word as-is (SW).
REQ-026 WAIT: on mem_rvalid SHALL capture lane selected by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), -> RESP.
REQ-027 mem_rvalid SHALL be ignored outside WAIT; rvalid in same cycle as gnt SHALL NOT be captured.
REQ-028 RESP: resp_valid=1, resp_data/resp_misaligned stable until resp_ready; on resp_ready -> IDLE.
REQ-029 Minimum latency SHALL be: store accept->resp_valid 2 cycles with gnt in first REQ cycle; load 3 cycles with rvalid one cycle after gnt.
REQ-030 Non-memory alu_operation with req_valid SHALL be accepted and answered in RESP with resp_data=0, resp_misaligned=0, no mem_req.
REQ-031 At most one op SHALL be outstanding; req_ready=0 in REQ/WAIT/RESP.

Reset
REQ-032 rst_n=1 SHALL force IDLE immediately, including mid-REQ/WAIT; in-flight op discarded, later rvalid ignored.
REQ-033 Reset values: req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_misaligned=0.

Structure
REQ-034 ALU_OPERATIONS_* codes SHALL come from the shared ISA definitions; FSM state enum and size-decode typedef SHALL reside in a shared core package.
REQ-035 One sub-module, load_extender (combinational lane select + extension), SHALL be instantiated.

Verification
REQ-036 SB addr=0x1003 data=0x000000AB, gnt immediate -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, resp_valid 2 cycles after accept.
REQ-037 LB addr=0x2001, rdata=0x1234F600 -> resp_data=0xFFFFFFF6; LBU same -> 0x000000F6.
REQ-038 LH addr=0x2002, rdata=0x80010000 -> resp_data=0xFFFF8001; LHU -> 0x00008001.
REQ-039 LW addr=0x3002 -> resp_misaligned=1, mem_req never asserted, resp_data=0.
REQ-040 LW with gnt delayed 3 cycles, resp_ready held 0 for 2 cycles -> mem_req and resp outputs held stable; req_ready=0 throughout.
REQ-041 Reset asserted in WAIT, then stray rvalid -> IDLE, resp_valid stays 0, req_ready=1.
